// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece logic: move encodings, scanner states
// and default playfield / piece dimensions.
package tetris_pkg;

    localparam int DEFAULT_FIELD_W = 10;
    localparam int DEFAULT_FIELD_H = 10;
    localparam int DEFAULT_BLK     = 3;

    typedef enum logic [1:0] {
        MODE_DOWN  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_PROBE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/piece_collision_scanner_cell_probe.sv
// Combinational test of one displaced piece cell against the field edges and
// the occupancy map.
module cell_probe
    import tetris_pkg::*;
#(
    parameter int FIELD_W = DEFAULT_FIELD_W,
    parameter int FIELD_H = DEFAULT_FIELD_H,
    parameter int BLK     = DEFAULT_BLK,
    parameter int COORD_W = 4,
    localparam int RC_W   = (BLK > 1) ? $clog2(BLK) : 1
) (
    input  logic [COORD_W-1:0]         blockX,
    input  logic [COORD_W-1:0]         blockY,
    input  logic [RC_W-1:0]            r,
    input  logic [RC_W-1:0]            c,
    input  logic signed [1:0]          dx,
    input  logic signed [1:0]          dy,
    input  logic [FIELD_W*FIELD_H-1:0] field,
    output logic                       out_of_bounds,
    output logic                       occupied
);

    localparam int TW = COORD_W + 2;
    localparam int IW = $clog2(FIELD_W * FIELD_H);

    logic signed [TW-1:0] tx;
    logic signed [TW-1:0] ty;
    logic [IW-1:0]        lin;

    // Two guard bits keep a step off the left edge (-1) distinguishable from a large column.
    assign tx = TW'(blockX) + TW'(c) + TW'(dx);
    assign ty = TW'(blockY) + TW'(r) + TW'(dy);

    assign out_of_bounds = tx[TW-1] || ty[TW-1]
                        || (tx >= $signed(TW'(FIELD_W)))
                        || (ty >= $signed(TW'(FIELD_H)));

    assign lin = IW'(ty[TW-2:0]) * IW'(FIELD_W) + IW'(tx[TW-2:0]);

    always_comb begin
        occupied = 1'b0;
        if (!out_of_bounds) begin
            occupied = field[lin];
        end
    end

endmodule

// File: rtl/piece_collision_scanner.sv
// Sequential collision checker: walks the latched piece mask one cell per cycle
// and stops at the first cell that would leave the field or hit an occupied cell.
module piece_collision_scanner
    import tetris_pkg::*;
#(
    parameter int FIELD_W = DEFAULT_FIELD_W,
    parameter int FIELD_H = DEFAULT_FIELD_H,
    parameter int BLK     = DEFAULT_BLK,
    parameter int COORD_W = 4,
    localparam int CNT_W  = $clog2(BLK * BLK),
    localparam int RC_W   = (BLK > 1) ? $clog2(BLK) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [FIELD_W*FIELD_H-1:0] field,
    input  logic [BLK*BLK-1:0]         block,
    input  logic [COORD_W-1:0]         blockX,
    input  logic [COORD_W-1:0]         blockY,
    output logic                       busy,
    output logic                       done,
    output logic                       collide,
    output logic [CNT_W-1:0]           hit_idx
);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    mode_t                mode_q;
    logic [BLK*BLK-1:0]   block_q;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic signed [1:0]    dx;
    logic signed [1:0]    dy;
    logic [RC_W-1:0]      r;
    logic [RC_W-1:0]      c;
    logic                 oob;
    logic                 occ;
    logic                 cell_hit;
    logic                 last_cell;

    assign r = RC_W'(cnt / CNT_W'(BLK));
    assign c = RC_W'(cnt % CNT_W'(BLK));

    always_comb begin
        dx = 2'sd0;
        dy = 2'sd0;
        case (mode_q)
            MODE_DOWN:  dy = 2'sd1;
            MODE_LEFT:  dx = -2'sd1;
            MODE_RIGHT: dx = 2'sd1;
            default:    ;
        endcase
    end

    cell_probe #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H),
        .BLK     (BLK),
        .COORD_W (COORD_W)
    ) u_probe (
        .blockX        (x_q),
        .blockY        (y_q),
        .r             (r),
        .c             (c),
        .dx            (dx),
        .dy            (dy),
        .field         (field),
        .out_of_bounds (oob),
        .occupied      (occ)
    );

    // Empty mask positions never collide, so an all-zero mask runs to the last cell.
    assign cell_hit  = block_q[cnt] && (oob || occ);
    assign last_cell = (cnt == CNT_W'(BLK * BLK - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (cell_hit || last_cell) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Results only move on the edge that enters DONE and are held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            mode_q  <= MODE_DOWN;
            block_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            collide <= 1'b0;
            hit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode_t'(mode);
                        block_q <= block;
                        x_q     <= blockX;
                        y_q     <= blockY;
                        cnt     <= '0;
                    end
                end
                SCAN: begin
                    if (cell_hit) begin
                        collide <= 1'b1;
                        hit_idx <= cnt;
                    end else if (last_cell) begin
                        collide <= 1'b0;
                        hit_idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_collision_scanner.sv
// Scoreboard bench for piece_collision_scanner: directed edge cases, random
// vectors against a behavioural model, busy/reset protocol checks.
module tb_piece_collision_scanner;
    import tetris_pkg::*;

    localparam int FW = 10;
    localparam int FH = 10;
    localparam int BK = 3;
    localparam int CW = 4;
    localparam int NC = BK * BK;
    localparam int IW = $clog2(NC);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [FW*FH-1:0] field = '0;
    logic [NC-1:0]    block = '0;
    logic [CW-1:0]    blockX = '0;
    logic [CW-1:0]    blockY = '0;
    logic             busy;
    logic             done;
    logic             collide;
    logic [IW-1:0]    hit_idx;

    piece_collision_scanner #(
        .FIELD_W (FW),
        .FIELD_H (FH),
        .BLK     (BK),
        .COORD_W (CW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .field   (field),
        .block   (block),
        .blockX  (blockX),
        .blockY  (blockY),
        .busy    (busy),
        .done    (done),
        .collide (collide),
        .hit_idx (hit_idx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          coll;
        logic [IW-1:0] idx;
        int            lat;
    } exp_t;

    // fbit: -1 empty field, -2 full field, otherwise the single occupied bit
    typedef struct {
        logic [1:0]    m;
        logic [NC-1:0] b;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        int            fbit;
        logic          coll;
        logic [IW-1:0] idx;
        int            lat;
    } case_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;

    function automatic exp_t model(input logic [FW*FH-1:0] f, input logic [NC-1:0] b,
                                   input int x, input int y, input logic [1:0] m);
        exp_t e;
        int dx, dy, tx, ty;
        dx = (m == MODE_LEFT) ? -1 : ((m == MODE_RIGHT) ? 1 : 0);
        dy = (m == MODE_DOWN) ? 1 : 0;
        e.coll = 1'b0;
        e.idx  = '0;
        e.lat  = NC + 1;
        for (int i = 0; i < NC; i++) begin
            if (b[i]) begin
                tx = x + (i % BK) + dx;
                ty = y + (i / BK) + dy;
                if (tx < 0 || tx >= FW || ty < 0 || ty >= FH || f[ty*FW+tx]) begin
                    e.coll = 1'b1;
                    e.idx  = IW'(i);
                    e.lat  = i + 2;
                    return e;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [FW*FH-1:0] make_field(input int fbit);
        logic [FW*FH-1:0] f;
        f = '0;
        if (fbit == -2) f = '1;
        else if (fbit >= 0) f[fbit] = 1'b1;
        return f;
    endfunction

    // Waits until IDLE, issues one start, and returns the cycle done rose in (-1 on timeout).
    task automatic launch(input logic [1:0] m, input logic [NC-1:0] b,
                          input logic [CW-1:0] x, input logic [CW-1:0] y, output int lat);
        repeat (2) @(negedge clock);
        mode = m; block = b; blockX = x; blockY = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nfail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        nvec++; if (collide !== 1'b0) begin nfail++; $display("[TB] FAIL reset_collide got %b want 0", collide); end
        nvec++; if (hit_idx !== '0) begin nfail++; $display("[TB] FAIL reset_hit_idx got %0d want 0", hit_idx); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    // Masks are SV literals, so cell 0 (r=0,c=0) is the rightmost bit.
    task automatic run_table(input string name, input case_t tbl[$]);
        exp_t e;
        int lat;
        foreach (tbl[k]) begin
            field = make_field(tbl[k].fbit);
            sb.push_back('{tbl[k].coll, tbl[k].idx, tbl[k].lat});
            launch(tbl[k].m, tbl[k].b, tbl[k].x, tbl[k].y, lat);
            e = sb.pop_front();
            nvec++; if (collide !== e.coll) begin nfail++; $display("[TB] FAIL %s[%0d] collide got %b want %b", name, k, collide, e.coll); end
            nvec++; if (hit_idx !== e.idx) begin nfail++; $display("[TB] FAIL %s[%0d] hit_idx got %0d want %0d", name, k, hit_idx, e.idx); end
            nvec++; if (lat != e.lat) begin nfail++; $display("[TB] FAIL %s[%0d] latency got %0d want %0d", name, k, lat, e.lat); end
        end
    endtask

    task automatic test_field_scan();
        case_t t[$];
        t.push_back('{MODE_DOWN,  9'b010_111_000, 4'd3, 4'd0, -1, 1'b0, 4'd0, 10});
        t.push_back('{MODE_DOWN,  9'b010_111_000, 4'd3, 4'd0, 24, 1'b1, 4'd4, 6});
        t.push_back('{MODE_RIGHT, 9'b010_111_000, 4'd6, 4'd0, -1, 1'b0, 4'd0, 10});
        t.push_back('{MODE_RIGHT, 9'b010_111_000, 4'd7, 4'd0, -1, 1'b1, 4'd5, 7});
        t.push_back('{MODE_PROBE, 9'b000_000_000, 4'd0, 4'd0, -2, 1'b0, 4'd0, 10});
        t.push_back('{MODE_PROBE, 9'b111_111_111, 4'd0, 4'd0, -2, 1'b1, 4'd0, 2});
        run_table("field_scan", t);
    endtask

    task automatic test_boundaries();
        case_t t[$];
        t.push_back('{MODE_LEFT,  9'b001_001_001, 4'd0, 4'd0, -1, 1'b1, 4'd0, 2});
        t.push_back('{MODE_LEFT,  9'b001_001_001, 4'd1, 4'd0, -1, 1'b0, 4'd0, 10});
        t.push_back('{MODE_DOWN,  9'b111_000_000, 4'd3, 4'd7, -1, 1'b1, 4'd6, 8});
        t.push_back('{MODE_DOWN,  9'b111_000_000, 4'd3, 4'd6, -1, 1'b0, 4'd0, 10});
        t.push_back('{MODE_PROBE, 9'b100_100_100, 4'd7, 4'd0, -1, 1'b0, 4'd0, 10});
        t.push_back('{MODE_PROBE, 9'b100_100_100, 4'd8, 4'd0, -1, 1'b1, 4'd2, 4});
        run_table("boundary", t);
    endtask

    task automatic test_random();
        exp_t e;
        int lat;
        logic [1:0]    m;
        logic [NC-1:0] b;
        logic [CW-1:0] x, y;
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < FW*FH; j++) field[j] = ($urandom_range(0, 6) == 0);
            b = NC'($urandom_range(0, (1 << NC) - 1));
            x = CW'($urandom_range(0, 11));
            y = CW'($urandom_range(0, 11));
            m = 2'($urandom_range(0, 3));
            sb.push_back(model(field, b, int'(x), int'(y), m));
            launch(m, b, x, y, lat);
            e = sb.pop_front();
            nvec++; if (collide !== e.coll) begin nfail++; $display("[TB] FAIL random[%0d] collide got %b want %b", k, collide, e.coll); end
            nvec++; if (hit_idx !== e.idx) begin nfail++; $display("[TB] FAIL random[%0d] hit_idx got %0d want %0d", k, hit_idx, e.idx); end
            nvec++; if (lat != e.lat) begin nfail++; $display("[TB] FAIL random[%0d] latency got %0d want %0d", k, lat, e.lat); end
        end
    endtask

    task automatic test_hold();
        int lat;
        field = '0;
        launch(MODE_RIGHT, 9'b010_111_000, 4'd7, 4'd0, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            block = NC'($urandom); mode = 2'($urandom); field = '1;
            nvec++; if (collide !== 1'b1) begin nfail++; $display("[TB] FAIL hold[%0d] collide got %b want 1", k, collide); end
            nvec++; if (hit_idx !== IW'(5)) begin nfail++; $display("[TB] FAIL hold[%0d] hit_idx got %0d want 5", k, hit_idx); end
            nvec++; if (done !== 1'b0) begin nfail++; $display("[TB] FAIL hold[%0d] done got %b want 0", k, done); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        field = '0;
        sb.push_back('{1'b1, IW'(0), 2});
        sb.push_back('{1'b0, IW'(0), 10});
        launch(MODE_LEFT, 9'b001_001_001, 4'd0, 4'd2, lat);
        e = sb.pop_front();
        nvec++; if (collide !== e.coll || hit_idx !== e.idx || lat != e.lat) begin
            nfail++; $display("[TB] FAIL b2b_first got %b/%0d/%0d want %b/%0d/%0d", collide, hit_idx, lat, e.coll, e.idx, e.lat); end
        launch(MODE_DOWN, 9'b010_111_000, 4'd3, 4'd0, lat);
        e = sb.pop_front();
        nvec++; if (collide !== e.coll || hit_idx !== e.idx || lat != e.lat) begin
            nfail++; $display("[TB] FAIL b2b_second got %b/%0d/%0d want %b/%0d/%0d", collide, hit_idx, lat, e.coll, e.idx, e.lat); end
    endtask

    task automatic test_busy_start_ignored();
        exp_t e;
        int ndone, first;
        logic busy1, busy_after, got_c;
        logic [IW-1:0] got_i;
        ndone = 0; first = -1; busy_after = 1'b1; got_c = 1'b0; got_i = '0;
        field = make_field(24);
        sb.push_back('{1'b1, IW'(4), 6});
        repeat (2) @(negedge clock);
        mode = MODE_DOWN; block = 9'b010_111_000; blockX = 4'd3; blockY = 4'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        busy1 = busy;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (done) begin
                ndone++;
                if (first < 0) begin first = cyc; got_c = collide; got_i = hit_idx; end
            end
            if (first >= 0 && cyc == first + 1) busy_after = busy;
            start = (cyc == 2 || cyc == 3);
            if (start) begin mode = MODE_LEFT; block = '1; blockX = 4'd0; end
            @(posedge clock); #1;
        end
        start = 1'b0;
        e = sb.pop_front();
        nvec++; if (busy1 !== 1'b1) begin nfail++; $display("[TB] FAIL busy_rise got %b want 1", busy1); end
        nvec++; if (ndone != 1) begin nfail++; $display("[TB] FAIL done_pulses got %0d want 1", ndone); end
        nvec++; if (first != e.lat) begin nfail++; $display("[TB] FAIL busy_latency got %0d want %0d", first, e.lat); end
        nvec++; if (got_c !== e.coll || got_i !== e.idx) begin
            nfail++; $display("[TB] FAIL busy_result got %b/%0d want %b/%0d", got_c, got_i, e.coll, e.idx); end
        nvec++; if (busy_after !== 1'b0) begin nfail++; $display("[TB] FAIL busy_fall got %b want 0", busy_after); end
    endtask

    task automatic test_reset_mid_scan();
        int ndone, nbusy;
        field = '0;
        repeat (2) @(negedge clock);
        mode = MODE_DOWN; block = 9'b010_111_000; blockX = 4'd3; blockY = 4'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nfail++; $display("[TB] FAIL abort_done got %b want 0", done); end
        nvec++; if (collide !== 1'b0) begin nfail++; $display("[TB] FAIL abort_collide got %b want 0", collide); end
        nvec++; if (hit_idx !== '0) begin nfail++; $display("[TB] FAIL abort_hit_idx got %0d want 0", hit_idx); end
        @(negedge clock); reset = 1'b0;
        ndone = 0; nbusy = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock); #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        nvec++; if (ndone != 0 || nbusy != 0) begin
            nfail++; $display("[TB] FAIL abort_no_done got done=%0d busy=%0d cycles want 0/0", ndone, nbusy); end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        test_reset();
        test_field_scan();
        test_boundaries();
        test_random();
        test_hold();
        test_back_to_back();
        test_busy_start_ignored();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
